uart_tx_scheduler: RTL and testbench

Shares one RS232 transmit line between two byte producers (processor core and debug/monitor port) in the RS232 subsystem. A round-robin arbiter grants one requester at a time. The granted byte is latched and serialized as an 8N1 frame. Every bit boundary is paced by the single-cycle `tick` pulse from the baud generator.

---
 rtl/uart_tx_scheduler.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Two-requester round-robin arbiter feeding a tick-paced serializer (8N1 by default).
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
module uart_tx_scheduler #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 req0,
  input  logic [DATA_BITS-1:0] data0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic [DATA_BITS-1:0] data1,
  output logic                 ack1,
  output logic                 tx,
  output logic                 busy,
  output logic                 grant_id
);

  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] sh_nxt;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 ack0_q, ack0_d;
  logic                 ack1_q, ack1_d;
  logic                 gid_q, gid_d;
  // Id of the last requester served; resets to 1 so req0 wins the first tie.
  logic                 rr_q, rr_d;
  logic                 pick1;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    gid_d   = gid_q;
    rr_d    = rr_q;
    pick1   = 1'b0;
    sh_nxt  = shreg_q >> 1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          pick1   = req1 && (!req0 || !rr_q);
          shreg_d = pick1 ? data1 : data0;
`ifdef UART_TX_PARITY_EN
          par_d   = pick1 ? ^data1 : ^data0;
`endif
          gid_d   = pick1;
          rr_d    = pick1;
          ack0_d  = !pick1;
          ack1_d  = pick1;
          busy_d  = 1'b1;
          state_d = S_SYNC;
        end
      end
      S_SYNC: begin
        if (tick) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          tx_d    = shreg_q[0];
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (cnt_q < LAST_BIT) begin
            shreg_d = sh_nxt;
            tx_d    = sh_nxt[0];
            cnt_d   = cnt_q + CW'(1);
          end else begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      gid_q   <= 1'b0;
      rr_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed/randomized bench for uart_tx_scheduler; frames are predicted from the
// requested bytes and the round-robin rule, then checked bit by bit on the line.
module tb_uart_tx_scheduler;
  localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = DB + 3;
`else
  localparam int NB = DB + 2;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [DB-1:0] data0 = '0, data1 = '0;
  logic ack0, ack1, tx, busy, grant_id;

  int n_chk = 0;
  int n_fail = 0;
  int per = 4;
  int tcnt = 0;
  logic last_gnt = 1'b1;

  uart_tx_scheduler #(.DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .tx(tx), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // baud generator: one-cycle pulse every 'per' clocks, changed on the falling edge
  always @(negedge clk) begin
    if (tcnt >= per - 1) begin
      tcnt = 0;
      tick = 1'b1;
    end else begin
      tcnt = tcnt + 1;
      tick = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return ~last;
    return r1;
  endfunction

  task automatic set_req(input logic id, input logic [DB-1:0] d);
    if (id) begin data1 = d; req1 = 1'b1; end
    else    begin data0 = d; req0 = 1'b1; end
  endtask

  task automatic drop_req(input logic id);
    if (id) req1 = 1'b0;
    else    req0 = 1'b0;
  endtask

  // Expects the next grant chosen by the round-robin model and checks the whole frame.
  task automatic check_frame(input int exp_lat, input int inj_bit,
                             input logic inj_id, input logic [DB-1:0] inj_d);
    logic          exp_id;
    logic [DB-1:0] d;
    logic [NB-1:0] bits;
    int            lat;
    bit            got;
    exp_id = pick(req0, req1, last_gnt);
    d = exp_id ? data1 : data0;
    bits = '0;
    for (int k = 0; k < DB; k++) bits[k+1] = d[k];
`ifdef UART_TX_PARITY_EN
    bits[DB+1] = ^d;
`endif
    bits[NB-1] = 1'b1;

    got = 0; lat = 0;
    for (int c = 0; c < 64 && !got; c++) begin
      step(); lat++;
      if (ack0 === 1'b1 || ack1 === 1'b1) got = 1;
    end
    chk("ack_seen", 32'(got), 32'd1);
    if (exp_lat > 0) chk("ack_latency", lat, exp_lat);
    chk("ack0", 32'(ack0), 32'(!exp_id));
    chk("ack1", 32'(ack1), 32'(exp_id));
    chk("grant_id", 32'(grant_id), 32'(exp_id));
    chk("busy_on", 32'(busy), 32'd1);
    last_gnt = exp_id;
    drop_req(exp_id);

    got = 0;
    for (int c = 0; c < 8 * per + 8 && !got; c++) begin
      step();
      chk("no_ack_sync", 32'({ack0, ack1}), 32'd0);
      if (tx === 1'b0) got = 1;
    end
    chk("start_seen", 32'(got), 32'd1);

    for (int i = 0; i < NB; i++) begin
      for (int j = 0; j < per; j++) begin
        if (!(i == 0 && j == 0)) step();
        if (j == 0 && i == inj_bit) set_req(inj_id, inj_d);
        chk($sformatf("tx_bit%0d", i), 32'(tx), 32'(bits[i]));
        chk("no_ack_busy", 32'({ack0, ack1}), 32'd0);
        chk("busy_frame", 32'(busy), 32'd1);
      end
    end
    step();
    chk("busy_off", 32'(busy), 32'd0);
    chk("tx_idle", 32'(tx), 32'd1);
  endtask

  initial begin
    logic nid;
    bit   got;

    // reset values
    reset = 1'b1;
    repeat (3) step();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    reset = 1'b0;
    step();

    // single byte, 4-clock bit period
    per = 4;
    set_req(1'b0, 8'hA5);
    check_frame(1, -1, 1'b0, 8'h00);

    // simultaneous requests right after reset: req0 first, then req1 back-to-back
    reset = 1'b1; step(); reset = 1'b0; last_gnt = 1'b1;
    set_req(1'b0, 8'h11);
    set_req(1'b1, 8'h22);
    check_frame(1, -1, 1'b0, 8'h00);
    check_frame(1, -1, 1'b0, 8'h00);

    // fairness: the served requester re-raises during its own frame
    per = $urandom_range(2, 6);
    set_req(1'b0, 8'($urandom));
    set_req(1'b1, 8'($urandom));
    for (int f = 0; f < 8 && (req0 || req1); f++) begin
      nid = pick(req0, req1, last_gnt);
      check_frame(1, (f < 4) ? 2 : -1, nid, 8'($urandom));
    end

    // request arriving mid-frame is held off until the first idle cycle
    per = $urandom_range(2, 5);
    set_req(1'b0, 8'($urandom));
    check_frame(1, 3, 1'b1, 8'($urandom));
    check_frame(1, -1, 1'b0, 8'h00);

    // reset during data bit 3 of a req1 frame
    per = 4;
    set_req(1'b1, 8'($urandom));
    step();
    chk("mid_ack1", 32'(ack1), 32'd1);
    drop_req(1'b1);
    got = 0;
    for (int c = 0; c < 8 * per + 8 && !got; c++) begin
      step();
      if (tx === 1'b0) got = 1;
    end
    chk("mid_start_seen", 32'(got), 32'd1);
    repeat (4 * per + 1) step();
    chk("mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_gid", 32'(grant_id), 32'd0);
    reset = 1'b0;
    last_gnt = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("mid_no_reack", 32'({ack0, ack1}), 32'd0);
      chk("mid_tx_idle", 32'(tx), 32'd1);
    end
    set_req(1'b0, 8'h3C);
    check_frame(1, -1, 1'b0, 8'h00);

    // parity byte with a tick every clock (tick coincides with the grant cycle)
    per = 1;
    set_req(1'b0, 8'h07);
    check_frame(1, -1, 1'b0, 8'h00);
    per = $urandom_range(2, 6);
    set_req(1'b1, 8'hFF);
    check_frame(1, -1, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
